keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator_if.sv | 10 +
 rtl/keypad_emulator.sv | 150 +++++++++++++++
 tb/tb_keypad_emulator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_emulator_if.sv
// Press-request handshake between a key source and the keypad emulator.
// The master offers key_code/key_valid; the emulator answers with key_ready.
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, key_valid, input key_ready);
    modport slave  (input key_code, key_valid, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad model: answers column strobes with row sense lines for one latched key.
// Contact-bounce emulation is compiled in only when KEYPAD_EMULATOR_BOUNCE_EN is defined.
module keypad_emulator #(
    parameter int HOLD_SCANS    = 4,
    parameter int GAP_CYCLES    = 8,
    parameter int BOUNCE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    keypad_emulator_if.slave kif,
    input  logic [3:0]       col,
    output logic [3:0]       fila,
    output logic             busy
);
    localparam int EW = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [EW-1:0] EDGE_LAST = EW'(HOLD_SCANS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BNC_LAST = BW'(BOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_PRESS  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    logic [BW-1:0] bnc_cnt_q, bnc_cnt_d;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd2,
        S_GAP   = 2'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [3:0]    key_q, key_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          col_prev_q, col_prev_d;
    logic [3:0]    fila_d;
    logic          col_cur;
    logic          rise;
    logic          pressed;

    // Only the strobe of the latched key's column matters.
    assign col_cur = col[key_q[1:0]];
    assign rise    = col_cur & ~col_prev_q;

    assign kif.key_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            edge_cnt_q <= '0;
            gap_cnt_q  <= '0;
            col_prev_q <= 1'b0;
            fila       <= '0;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            bnc_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            edge_cnt_q <= edge_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            col_prev_q <= col_prev_d;
            fila       <= fila_d;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            bnc_cnt_q  <= bnc_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        edge_cnt_d = edge_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        col_prev_d = col_cur;
        pressed    = 1'b0;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
        bnc_cnt_d  = bnc_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (kif.key_valid) begin
                    key_d      = kif.key_code;
                    edge_cnt_d = '0;
                    gap_cnt_d  = '0;
                    // Priming prev high means a strobe already up on entry is not an edge.
                    col_prev_d = 1'b1;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
                    bnc_cnt_d  = '0;
                    state_d    = S_BOUNCE;
`else
                    state_d    = S_PRESS;
`endif
                end
            end
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            S_BOUNCE: begin
                // Contact chatters pressed/released, starting pressed.
                pressed = ~bnc_cnt_q[0];
                if (bnc_cnt_q == BNC_LAST) begin
                    bnc_cnt_d  = '0;
                    edge_cnt_d = '0;
                    col_prev_d = 1'b1;
                    state_d    = S_PRESS;
                end else begin
                    bnc_cnt_d = bnc_cnt_q + 1'b1;
                end
            end
`endif
            S_PRESS: begin
                pressed = 1'b1;
                if (rise) begin
                    if (edge_cnt_q == EDGE_LAST) begin
                        edge_cnt_d = '0;
                        gap_cnt_d  = '0;
                        state_d    = S_GAP;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fila_d = (pressed && col_cur) ? (4'b0001 << key_q[3:2]) : 4'b0000;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: vector table for full presses plus
// hand sequences for stalled scans, mid-press reset and bounce behaviour.
module tb_keypad_emulator;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col;
    logic [3:0] fila;
    logic       busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    keypad_emulator_if kif();

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    localparam int BNC = 3;
`else
    localparam int BNC = 0;
`endif

    keypad_emulator #(.HOLD_SCANS(4), .GAP_CYCLES(8), .BOUNCE_CYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif.slave),
        .col   (col),
        .fila  (fila),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic [3:0] col;
        logic       bnc;
        logic [3:0] fila;
        logic       rdy;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic kv, logic [3:0] kc, logic [3:0] c, logic b,
                                logic [3:0] f, logic r, logic bz);
        vec_t v;
        v.kv = kv; v.kc = kc; v.col = c; v.bnc = b; v.fila = f; v.rdy = r; v.busy = bz;
        return v;
    endfunction

    function automatic logic [5:0] obs();
        return {fila, kif.key_ready, busy};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: fila/ready/busy got %b/%b/%b want %b/%b/%b",
                     name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] kc, input logic [3:0] c);
        kif.key_valid = kv;
        kif.key_code  = kc;
        col           = c;
        @(posedge clk);
        #1;
    endtask

    task automatic skip_bounce();
        for (int i = 0; i < BNC; i++) begin
            step(1'b0, 4'h0, 4'b0000);
            check($sformatf("bounce_wait%0d", i), obs(), 6'b0000_0_1);
        end
    endtask

    initial begin
        logic [3:0] exp_b[6];
        int bad;
        int cnt;

        // Key 0110 (row 1, col 2) against a rotating one-hot scan.
        tbl.push_back(mk(1, 4'b0110, 4'b0000, 1, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 4'b0010, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b1000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 4'b0010, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b1000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 4'b0010, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b1000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 4'b0010, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b1000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b1000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 4'b0000, 1, 0));
        // Key 0001 (row 0, col 1) with a competing request held high throughout.
        tbl.push_back(mk(1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0010, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b1000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b1010, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0010, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0011, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0010, 0, 4'b0001, 0, 1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0));

        // Reset held with the scan running and a request offered.
        reset         = 1'b0;
        kif.key_valid = 1'b1;
        kif.key_code  = 4'b0110;
        col           = 4'b0001;
        #1;
        check("reset_async", obs(), 6'b0000_1_0);
        for (int i = 0; i < 8; i++) begin
            col = 4'b0001 << (i % 4);
            @(posedge clk);
            #1;
            check($sformatf("reset_scan%0d", i), obs(), 6'b0000_1_0);
        end
        kif.key_valid = 1'b0;
        reset         = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].kv, tbl[i].kc, tbl[i].col);
            check($sformatf("row%0d", i), obs(), {tbl[i].fila, tbl[i].rdy, tbl[i].busy});
            if (tbl[i].bnc) skip_bounce();
        end

        // Scanner stalls with col = 0: the key stays held until four strobes arrive.
        step(1'b1, 4'b0110, 4'b0000);
        check("stall_accept", obs(), 6'b0000_0_1);
        skip_bounce();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'h0, 4'b0000);
            if (obs() !== 6'b0000_0_1) bad++;
        end
        check("stall_hold", {bad[4:0], 1'b0}, 6'b0);
        for (int p = 0; p < 4; p++) begin
            step(1'b0, 4'h0, 4'b0100);
            check($sformatf("stall_pulse%0d", p), obs(), 6'b0010_0_1);
            if (p < 3) begin
                step(1'b0, 4'h0, 4'b0000);
                check($sformatf("stall_low%0d", p), obs(), 6'b0000_0_1);
            end
        end
        cnt = 0;
        while (!kif.key_ready && cnt < 20) begin
            step(1'b0, 4'h0, 4'b0000);
            cnt++;
        end
        check("stall_gap_len", {cnt[4:0], kif.key_ready}, {5'd8, 1'b1});

        // Reset mid-press drops the row line without waiting for a clock edge.
        step(1'b1, 4'b0001, 4'b0000);
        check("rst_accept", obs(), 6'b0000_0_1);
        skip_bounce();
        step(1'b0, 4'h0, 4'b0000);
        step(1'b0, 4'h0, 4'b0010);
        check("rst_pressed", obs(), 6'b0001_0_1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_press", obs(), 6'b0000_1_0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 4'b0110, 4'b0000);
        check("rst_first_accept", obs(), 6'b0000_0_1);

        // Column held high from acceptance: bounce chatter (if built) then a steady press.
        reset = 1'b0;
        #1;
        reset = 1'b1;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
        exp_b = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
        exp_b = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        step(1'b1, 4'b0110, 4'b0100);
        check("held_accept", obs(), 6'b0000_0_1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'h0, 4'b0100);
            check($sformatf("held%0d", i), obs(), {exp_b[i], 1'b0, 1'b1});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
